// File: rtl/mercury_uop_scoreboard.sv
// Issue-stage scoreboard: holds one decoded uop, blocks it on RAW/WAW against a
// per-register busy table, and releases it downstream once its operands are clean.

module mercury_uop_busy_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic set,
    input  logic clr,
    output logic busy
);
    // Set wins over clear: the issuing writer is younger than the one retiring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     busy <= 1'b0;
        else if (flush) busy <= 1'b0;
        else if (set)   busy <= 1'b1;
        else if (clr)   busy <= 1'b0;
    end
endmodule

module mercury_uop_scoreboard #(
    parameter int NUM_LREG    = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [14:0]            in_uop,
    input  logic                   in_rs1_ren,
    input  logic                   in_rs2_ren,
    input  logic                   in_rd_wen,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [14:0]            out_uop,
    output logic                   out_rd_wen,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_ldst,
    output logic [NUM_LREG-1:0]    busy_vec,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic [4:0] lsrc1;
        logic [4:0] lsrc2;
        logic [4:0] ldst;
    } uop_info_t;

    uop_info_t           hold_uop;
    logic                hold_ren1, hold_ren2, hold_wen, hold_valid;
    logic [NUM_LREG-1:0] wb_mask, eff_busy;
    logic                raw, waw, hazard, in_fire, out_fire;

    always_comb begin
        wb_mask = '0;
        if (wb_valid) wb_mask = NUM_LREG'(1) << wb_ldst;
        eff_busy    = busy_vec & ~wb_mask;
        eff_busy[0] = 1'b0;
    end

    assign raw       = (hold_ren1 & eff_busy[hold_uop.lsrc1]) |
                       (hold_ren2 & eff_busy[hold_uop.lsrc2]);
    assign waw       = hold_wen & eff_busy[hold_uop.ldst];
    assign hazard    = raw | waw;

    assign out_valid = hold_valid & ~hazard & ~flush;
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = (~hold_valid | out_fire) & ~flush;
    assign in_fire   = in_valid & in_ready;

    assign out_uop    = hold_uop;
    assign out_rd_wen = hold_wen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_uop   <= '0;
            hold_ren1  <= 1'b0;
            hold_ren2  <= 1'b0;
            hold_wen   <= 1'b0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (in_fire) begin
            hold_valid <= 1'b1;
            hold_uop   <= in_uop;
            hold_ren1  <= in_rs1_ren;
            hold_ren2  <= in_rs2_ren;
            hold_wen   <= in_rd_wen;
        end else if (out_fire) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (hold_valid && hazard && !flush && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

    for (genvar r = 0; r < NUM_LREG; r++) begin : g_busy
        logic set_r;
        // x0 is hardwired clean, so it never gets a set.
        assign set_r = (r != 0) && out_fire && hold_wen && (hold_uop.ldst == 5'(r));
        mercury_uop_busy_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .set   (set_r),
            .clr   (wb_mask[r]),
            .busy  (busy_vec[r])
        );
    end
endmodule

// File: tb/tb_mercury_uop_scoreboard.sv
// Bench for mercury_uop_scoreboard: directed scenarios plus randomized traffic,
// all checked every cycle against a register-level behavioural model.

module tb_mercury_uop_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, in_valid = 1'b0, in_rs1_ren = 1'b0, in_rs2_ren = 1'b0, in_rd_wen = 1'b0;
    logic [14:0] in_uop = '0;
    logic        out_ready = 1'b0, wb_valid = 1'b0;
    logic [4:0]  wb_ldst = '0;
    logic        in_ready, out_valid, out_rd_wen;
    logic [14:0] out_uop;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;

    int pass_cnt = 0, total_cnt = 0;

    mercury_uop_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_uop(in_uop), .in_rs1_ren(in_rs1_ren), .in_rs2_ren(in_rs2_ren), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop), .out_rd_wen(out_rd_wen),
        .wb_valid(wb_valid), .wb_ldst(wb_ldst), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: which registers have an outstanding writer, and the uop waiting to issue.
    bit       m_busy[32];
    bit       m_hv, m_r1, m_r2, m_w;
    int       m_a, m_b, m_d;
    int       m_stall;
    bit       e_ov, e_ir, e_hz;
    bit       s_ov, s_ir;
    logic [14:0] s_uop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [14:0] U(input int a, input int b, input int d);
        logic [4:0] x, y, z;
        x = 5'(a); y = 5'(b); z = 5'(d);
        return {x, y, z};
    endfunction

    function automatic logic [31:0] m_busy_word();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // A source waits if it reads a register someone is still writing, unless that
    // write is retiring right now; x0 never waits.
    function automatic bit waits(input int idx, input bit en);
        if (!en || idx == 0 || !m_busy[idx]) return 1'b0;
        if (wb_valid && int'(wb_ldst) == idx) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_hv = 0; m_r1 = 0; m_r2 = 0; m_w = 0; m_a = 0; m_b = 0; m_d = 0; m_stall = 0;
    endtask

    task automatic eval_and_compare();
        e_hz = waits(m_a, m_r1) || waits(m_b, m_r2) || waits(m_d, m_w);
        e_ov = m_hv && !e_hz && !flush;
        e_ir = (!m_hv || (e_ov && out_ready)) && !flush;
        check("out_valid", 32'(out_valid), 32'(e_ov));
        check("in_ready", 32'(in_ready), 32'(e_ir));
        check("busy_vec", busy_vec, m_busy_word());
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (m_hv) begin
            check("out_uop", 32'(out_uop), 32'(U(m_a, m_b, m_d)));
            check("out_rd_wen", 32'(out_rd_wen), 32'(m_w));
        end
        s_ov = out_valid; s_ir = in_ready; s_uop = out_uop;
    endtask

    task automatic model_step();
        bit ofire, ifire;
        ofire = e_ov && out_ready;
        ifire = in_valid && e_ir;
        if (m_hv && e_hz && !flush && m_stall < 65535) m_stall++;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_hv = 0;
        end else begin
            if (wb_valid) m_busy[wb_ldst] = 1'b0;
            if (ofire && m_w && m_d != 0) m_busy[m_d] = 1'b1;
            if (ifire) begin
                m_hv = 1; m_a = int'(in_uop[14:10]); m_b = int'(in_uop[9:5]); m_d = int'(in_uop[4:0]);
                m_r1 = in_rs1_ren; m_r2 = in_rs2_ren; m_w = in_rd_wen;
            end else if (ofire) m_hv = 0;
        end
    endtask

    task automatic drive(input bit fl, input bit iv, input logic [14:0] u, input bit r1, input bit r2,
                         input bit w, input bit ordy, input bit wbv, input int wbd);
        @(negedge clk);
        flush = fl; in_valid = iv; in_uop = u; in_rs1_ren = r1; in_rs2_ren = r2; in_rd_wen = w;
        out_ready = ordy; wb_valid = wbv; wb_ldst = 5'(wbd);
        #1 eval_and_compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input bit ordy);
        drive(0, 0, '0, 0, 0, 0, ordy, 0, 0);
    endtask

    task automatic do_flush();
        drive(1, 0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    int snap;

    initial begin
        model_reset();
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_uop", 32'(out_uop), 32'd0);
        check("reset_busy", busy_vec, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Back-to-back independent uops
        drive(0, 1, U(1, 2, 3), 1, 1, 1, 1, 0, 0);
        drive(0, 1, U(4, 5, 6), 1, 1, 1, 1, 0, 0);
        check("b2b_first_fire", 32'(s_ov), 32'd1);
        idle(1);
        check("b2b_second_fire", 32'(s_ov), 32'd1);
        check("b2b_busy", busy_vec, 32'h48);
        do_flush();

        // RAW stall released by same-cycle writeback
        drive(0, 1, U(1, 2, 5), 1, 1, 1, 1, 0, 0);
        drive(0, 1, U(5, 0, 7), 1, 0, 1, 1, 0, 0);
        snap = int'(stall_cnt);
        idle(1);
        check("raw_blocked", 32'(s_ov), 32'd0);
        idle(1);
        check("raw_stall_cnt", 32'(stall_cnt), 32'(snap + 2));
        drive(0, 0, '0, 0, 0, 0, 1, 1, 5);
        check("raw_wakeup", 32'(s_ov), 32'd1);
        do_flush();

        // Set/clear collision on the same register
        drive(0, 1, U(1, 2, 5), 1, 1, 1, 1, 0, 0);
        drive(0, 1, U(1, 2, 5), 1, 1, 1, 1, 0, 0);
        idle(1);
        check("waw_blocked", 32'(s_ov), 32'd0);
        drive(0, 0, '0, 0, 0, 0, 1, 1, 5);
        check("collide_fire", 32'(s_ov), 32'd1);
        check("collide_busy5", 32'(busy_vec[5]), 32'd1);
        do_flush();

        // x0 destination never becomes busy
        drive(0, 1, U(0, 0, 0), 1, 1, 1, 1, 0, 0);
        drive(0, 1, U(0, 0, 8), 1, 1, 1, 1, 0, 0);
        check("x0_no_stall", 32'(s_ov), 32'd1);
        idle(1);
        check("x0_second_fire", 32'(s_ov), 32'd1);
        check("x0_busy", busy_vec, 32'h100);
        do_flush();

        // Backpressure holds the uop steady
        drive(0, 1, U(1, 2, 3), 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, U(4, 4, 4), 1, 1, 1, 0, 0, 0);
            check("bp_uop", 32'(s_uop), 32'(U(1, 2, 3)));
            check("bp_in_ready", 32'(s_ir), 32'd0);
        end
        drive(0, 1, U(4, 4, 4), 1, 1, 1, 1, 0, 0);
        check("bp_release_accept", 32'(s_ir), 32'd1);
        check("bp_next_uop", 32'(out_uop), 32'(U(4, 4, 4)));
        do_flush();

        // Flush with busy registers and a held uop
        for (int r = 4; r < 8; r++) drive(0, 1, U(0, 0, r), 0, 0, 1, 1, 0, 0);
        drive(0, 1, U(1, 1, 9), 1, 1, 1, 1, 0, 0);
        check("flush_pre_busy", busy_vec, 32'h0F0);
        drive(1, 1, U(2, 2, 10), 1, 1, 1, 1, 0, 0);
        check("flush_busy", busy_vec, 32'd0);
        idle(1);
        check("flush_nothing_held", 32'(s_ov), 32'd0);

        // Async reset in the middle of a stall
        drive(0, 1, U(0, 0, 5), 0, 0, 1, 1, 0, 0);
        drive(0, 1, U(5, 0, 1), 1, 0, 1, 1, 0, 0);
        idle(1);
        idle(1);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", busy_vec, 32'd0);
        model_reset();
        @(posedge clk); #3 rst_n = 1'b1;

        // Randomized traffic on a narrow register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            bit fl, iv, wbv, ordy;
            int wbd;
            fl   = ($urandom_range(0, 59) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            wbv  = ($urandom_range(0, 1) == 1);
            wbd  = $urandom_range(0, 7);
            drive(fl, iv, U($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 1'($urandom), ordy, wbv, wbd);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
